// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: frames three received bytes (A, B, Op) into operands for an
// external registered ALU, then returns the ALU result as a single byte.
//
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous, active-high reset
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_rx_done     one-cycle pulse per received byte
//   i_tx_done     one-cycle pulse when the transmitter finishes a byte
//   i_alu_result  ALU result (one clock of latency after operands change)
//   o_alu_A/B     registered ALU operands
//   o_alu_Op      registered ALU operation code
//   o_tx_data     result byte for the transmitter
//   o_tx_start    one-cycle transmit request
//   o_busy        high while executing or transmitting
//   o_error       one-cycle pulse when a partial frame times out
module alu_uart_ctrl #(
  parameter int unsigned N       = 8,
  parameter int unsigned NSel    = 6,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_rx_done,
  input  logic            i_tx_done,
  input  logic [N-1:0]    i_alu_result,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [DBIT-1:0] o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy,
  output logic            o_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_OP,
    S_EXEC,
    S_CAPTURE,
    S_WAIT_TX
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            expired;

  // Counter reads TIMEOUT-1 during the TIMEOUT-th idle cycle in S_B/S_OP.
  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_A;
      cnt_q      <= '0;
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_Op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      case (state_q)
        S_A: begin
          if (i_rx_done) begin
            o_alu_A <= i_rx_data[N-1:0];
            cnt_q   <= '0;
            state_q <= S_B;
          end
        end
        S_B: begin
          // A byte arriving in the expiry cycle wins over the timeout.
          if (i_rx_done) begin
            o_alu_B <= i_rx_data[N-1:0];
            cnt_q   <= '0;
            state_q <= S_OP;
          end else if (expired) begin
            cnt_q   <= '0;
            o_error <= 1'b1;
            state_q <= S_A;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OP: begin
          if (i_rx_done) begin
            o_alu_Op <= i_rx_data[NSel-1:0];
            cnt_q    <= '0;
            o_busy   <= 1'b1;
            state_q  <= S_EXEC;
          end else if (expired) begin
            cnt_q   <= '0;
            o_error <= 1'b1;
            state_q <= S_A;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // ALU registers the new operands on this edge.
        S_EXEC: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          o_tx_data  <= DBIT'(i_alu_result);
          o_tx_start <= 1'b1;
          state_q    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            o_busy  <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl. A behavioural ALU with one clock of
// latency stands in for the real ALU; expected responses are queued by the
// stimulus and popped by an independent monitor.
module tb_alu_uart_ctrl;
  localparam int unsigned N       = 8;
  localparam int unsigned NSel    = 6;
  localparam int unsigned DBIT    = 8;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DBIT-1:0] rx_data;
  logic            rx_done;
  logic            tx_done;
  logic [N-1:0]    alu_result;
  logic [N-1:0]    alu_A;
  logic [N-1:0]    alu_B;
  logic [NSel-1:0] alu_Op;
  logic [DBIT-1:0] tx_data;
  logic            tx_start;
  logic            busy;
  logic            error;

  alu_uart_ctrl #(
    .N      (N),
    .NSel   (NSel),
    .DBIT   (DBIT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_result),
    .o_alu_A     (alu_A),
    .o_alu_B     (alu_B),
    .o_alu_Op    (alu_Op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: MIPS-style function codes, anything else yields 0.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return 8'(sa >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_ref(alu_A, alu_B, alu_Op);

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        tx_q[$];
  int unsigned err_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every transmit request and error pulse must match a queued expectation.
  exp_t        mon_e;
  int unsigned mon_c;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (tx_q.size() == 0) begin
        check("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        mon_e = tx_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_e.data));
        check("tx_latency", cyc, mon_e.cyc);
      end
    end
    if (error === 1'b1) begin
      if (err_q.size() == 0) begin
        check("unexpected_error", 32'd1, 32'd0);
      end else begin
        mon_c = err_q.pop_front();
        check("error_cycle", cyc, mon_c);
      end
    end
  end

  // Called at a negedge; drives one byte for one cycle and returns its cycle.
  task automatic send_byte(input logic [7:0] b, output int unsigned c);
    rx_data = b;
    rx_done = 1'b1;
    c       = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  // Full frame with gap g1 after A and g2 after B; transmitter finishes after hold cycles.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int unsigned g1, input int unsigned g2,
                          input int unsigned hold);
    int unsigned c;
    exp_t e;
    send_byte(a, c);
    idle(g1);
    send_byte(b, c);
    check("busy_before_op", 32'(busy), 32'd0);
    idle(g2);
    e.data = alu_ref(a, b, op);
    send_byte(op, c);
    e.cyc = c + 3;
    tx_q.push_back(e);
    check("busy_exec", 32'(busy), 32'd1);
    wait_tx_start("tx_start_timeout");
    idle(hold);
    check("busy_wait_tx", 32'(busy), 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_A"}, 32'(alu_A), 32'd0);
    check({name, "_B"}, 32'(alu_B), 32'd0);
    check({name, "_Op"}, 32'(alu_Op), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
    check({name, "_ctl"}, {29'd0, tx_start, busy, error}, 32'd0);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

  initial begin
    int unsigned c;
    exp_t e;
    rst     = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check_all_zero("reset");

    // Directed frames.
    do_frame(8'h05, 8'h03, 8'h20, 0, 0, 2);
    do_frame(8'h03, 8'h05, 8'h22, 1, 2, 0);
    do_frame(8'h0F, 8'hF0, 8'h27, 0, 1, 3);
    do_frame(8'hAA, 8'h55, 8'h3F, 2, 0, 1);

    // Timeout after a lone A byte; registers hold their values.
    send_byte(8'h07, c);
    err_q.push_back(c + TIMEOUT + 1);
    idle(TIMEOUT + 2);
    check("error_pending", err_q.size(), 32'd0);
    check("hold_A_after_timeout", 32'(alu_A), 32'h07);
    check("busy_after_timeout", 32'(busy), 32'd0);
    do_frame(8'h01, 8'h02, 8'h20, 0, 0, 1);

    // Byte during S_WAIT_TX is dropped.
    send_byte(8'h0A, c);
    send_byte(8'h0B, c);
    e.data = alu_ref(8'h0A, 8'h0B, 8'h25);
    send_byte(8'h25, c);
    e.cyc = c + 3;
    tx_q.push_back(e);
    wait_tx_start("tx_start_timeout_wt");
    idle(1);
    send_byte(8'h09, c);
    check("A_unchanged_wait_tx", 32'(alu_A), 32'h0A);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    do_frame(8'h02, 8'h02, 8'h24, 0, 0, 0);

    // Reset while in S_EXEC: no transmission for the abandoned frame.
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    send_byte(8'h20, c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_exec");
    idle(4);
    do_frame(8'h04, 8'h01, 8'h20, 0, 0, 1);

    // Reset while in S_WAIT_TX.
    send_byte(8'h33, c);
    send_byte(8'h44, c);
    e.data = alu_ref(8'h33, 8'h44, 8'h26);
    send_byte(8'h26, c);
    e.cyc = c + 3;
    tx_q.push_back(e);
    wait_tx_start("tx_start_timeout_rst");
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_wait_tx");
    do_frame(8'h04, 8'h01, 8'h20, 0, 0, 1);

    // Op byte coincident with the expiry cycle in S_OP: accepted, no error.
    do_frame(8'h10, 8'h20, 8'h22, 0, TIMEOUT - 1, 1);
    // B byte coincident with expiry in S_B.
    do_frame(8'h81, 8'h02, 8'h03, TIMEOUT - 1, 0, 0);

    // Random frames.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] op;
      if ($urandom_range(0, 4) == 0) op = 8'($urandom_range(0, 255));
      else op = {2'b00, ops[$urandom_range(0, 7)]};
      do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), op,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    idle(5);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("err_queue_drained", err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_uart_ctrl.md
ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter N, default 8, ALU operand/result width; SHALL satisfy N <= DBIT.
REQ-002 Parameter NSel, default 6, ALU operation code width; SHALL satisfy NSel <= DBIT.
REQ-003 Parameter DBIT, default 8, serial byte width.
REQ-004 Parameter TIMEOUT, default 1000000, idle-cycle limit inside a partial frame; SHALL be >= 2.
REQ-005 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_rx_data  in  DBIT  received byte; valid only while i_rx_done is high.
REQ-008 i_rx_done  in  1  one-cycle pulse, byte received.
REQ-009 i_tx_done  in  1  one-cycle pulse, transmitter finished the byte.
REQ-010 i_alu_result  in  N  registered ALU result (ALU has one-clock latency).
REQ-011 o_alu_A, o_alu_B  out  N each  registered operands to the ALU.
REQ-012 o_alu_Op  out  NSel  registered operation code to the ALU.
REQ-013 o_tx_data  out  DBIT  result byte to transmitter.
REQ-014 o_tx_start  out  1  one-cycle pulse requesting transmission.
REQ-015 o_busy  out  1  high while executing or transmitting.
REQ-016 o_error  out  1  one-cycle pulse on frame timeout.

Function
REQ-017 Frame = three bytes in order A, B, Op; response = one byte, the ALU result.
REQ-018 States SHALL be S_A, S_B, S_OP, S_EXEC, S_CAPTURE, S_WAIT_TX.
REQ-019 S_A: on i_rx_done, o_alu_A <= i_rx_data[N-1:0], go S_B; else stay.
REQ-020 S_B: on i_rx_done, o_alu_B <= i_rx_data[N-1:0], go S_OP.
REQ-021 S_OP: on i_rx_done, o_alu_Op <= i_rx_data[NSel-1:0], go S_EXEC.
REQ-022 S_EXEC: unconditional, one cycle, go S_CAPTURE (ALU samples new operands at this edge).
REQ-023 S_CAPTURE: o_tx_data <= zero-extended i_alu_result, o_tx_start <= 1 for exactly one cycle, go S_WAIT_TX.
REQ-024 Latency: o_tx_start SHALL be high in the 3rd cycle after the cycle in which the Op i_rx_done was high (edges k+1 latch Op, k+2 ALU, k+3 capture).
REQ-025 S_WAIT_TX: on i_tx_done go S_A; else stay, no timeout.
REQ-026 i_rx_done in S_EXEC, S_CAPTURE, S_WAIT_TX SHALL be ignored; byte dropped, no register change.
REQ-027 i_tx_done outside S_WAIT_TX SHALL be ignored.
REQ-028 o_busy SHALL be high exactly while state is S_EXEC, S_CAPTURE or S_WAIT_TX.
REQ-029 Timeout counter cleared on entry to S_B or S_OP and on every i_rx_done; increments each cycle in S_B/S_OP.
REQ-030 After TIMEOUT consecutive cycles in S_B/S_OP without i_rx_done: go S_A, o_error high one cycle.
REQ-031 i_rx_done in the expiry cycle SHALL win: byte accepted, no o_error.
REQ-032 Operand/op registers SHALL hold their values between frames and after timeout; partial frame fields overwritten only by new bytes.
REQ-033 Op codes are passed unchecked; invalid codes yield the ALU default result 0.

Reset
REQ-034 While i_reset is high at a rising edge: state <= S_A; o_alu_A, o_alu_B, o_alu_Op, o_tx_data <= 0; o_tx_start, o_busy, o_error <= 0; counter <= 0.
REQ-035 Reset SHALL take priority over all inputs in any state; an in-flight frame is abandoned, no o_tx_start issued for it.

Verification
REQ-036 Bytes 0x05, 0x03, 0x20 -> o_tx_data 0x08, single o_tx_start pulse per REQ-024, o_busy high until i_tx_done.
REQ-037 Bytes 0x03, 0x05, 0x22 -> o_tx_data 0xFE; bytes 0x0F, 0xF0, 0x27 -> 0x00; bytes 0xAA, 0x55, 0x3F (invalid) -> 0x00.
REQ-038 Byte 0x07 then silence TIMEOUT cycles -> o_error one pulse, state S_A; next 0x01, 0x02, 0x20 -> 0x03.
REQ-039 Byte 0x09 arriving during S_WAIT_TX -> ignored; next frame 0x02, 0x02, 0x24 -> 0x02.
REQ-040 i_reset asserted in S_WAIT_TX or S_EXEC -> all outputs 0 next cycle, no o_tx_start; following frame 0x04, 0x01, 0x20 -> 0x05.
REQ-041 Op i_rx_done coincident with timeout expiry in S_OP -> no o_error, result transmitted.
